// File: rtl/multmod_arbiter.sv
// Round-robin arbiter sharing one multmod among NREQ requesters, one job at a time.
// Optional per-requester grant counters on output grant_cnt when MULTMOD_ARB_STATS_EN is defined.
module multmod_arbiter #(
  parameter int N    = 448,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ*N-1:0] X,
  input  logic [NREQ*N-1:0] Y,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  output logic              req_busy,
  output logic [N-1:0]      Z,
  output logic [NREQ-1:0]   res_valid,
  input  logic [NREQ-1:0]   res_ready,
  output logic [N-1:0]      m_X,
  output logic [N-1:0]      m_Y,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  input  logic              m_req_busy,
  input  logic [N-1:0]      m_Z,
  input  logic              m_res_valid,
  output logic              m_res_ready
`ifdef MULTMOD_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] grant_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    DRAIN   = 3'd3,
    DELIVER = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     g_q, g_d;
  logic [N-1:0]      m_x_q, m_x_d;
  logic [N-1:0]      m_y_q, m_y_d;
  logic [N-1:0]      z_q, z_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic [NREQ-1:0]   res_valid_q, res_valid_d;
  logic              m_req_valid_q, m_req_valid_d;
  logic              m_res_ready_q, m_res_ready_d;
  logic              req_busy_q, req_busy_d;

  logic              found_s;
  logic [PW-1:0]     win_s;
  logic              unused_s;

  assign unused_s = m_req_busy;

  // Round-robin pick: first pending requester at or after ptr, wrapping.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_s && req_valid[(int'(ptr_q) + k) % NREQ]) begin
        found_s = 1'b1;
        win_s   = PW'((int'(ptr_q) + k) % NREQ);
      end else begin
        found_s = found_s;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    g_d           = g_q;
    m_x_d         = m_x_q;
    m_y_d         = m_y_q;
    z_d           = z_q;
    req_ready_d   = '0;
    res_valid_d   = res_valid_q;
    m_req_valid_d = m_req_valid_q;
    m_res_ready_d = m_res_ready_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          g_d                = win_s;
          m_x_d              = X[int'(win_s)*N +: N];
          m_y_d              = Y[int'(win_s)*N +: N];
          req_ready_d[win_s] = 1'b1;
          m_req_valid_d      = 1'b1;
          state_d            = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (m_req_valid_q && m_req_ready) begin
          m_req_valid_d = 1'b0;
          state_d       = WAIT;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        if (m_res_valid) begin
          z_d           = m_Z;
          m_res_ready_d = 1'b1;
          state_d       = DRAIN;
        end else begin
          state_d = WAIT;
        end
      end
      DRAIN: begin
        // Keep m_res_ready up until multmod has seen the handshake and retracted valid.
        if (!m_res_valid) begin
          m_res_ready_d    = 1'b0;
          res_valid_d      = '0;
          res_valid_d[g_q] = 1'b1;
          state_d          = DELIVER;
        end else begin
          state_d = DRAIN;
        end
      end
      DELIVER: begin
        if (res_ready[g_q]) begin
          res_valid_d = '0;
          ptr_d       = (g_q == PW'(NREQ - 1)) ? '0 : g_q + PW'(1);
          state_d     = IDLE;
        end else begin
          state_d = DELIVER;
        end
      end
      default: begin
        state_d       = IDLE;
        res_valid_d   = '0;
        m_req_valid_d = 1'b0;
        m_res_ready_d = 1'b0;
      end
    endcase
    req_busy_d = (state_d != IDLE);
  end

  // State and output registers; synchronous reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      g_q           <= '0;
      m_x_q         <= '0;
      m_y_q         <= '0;
      z_q           <= '0;
      req_ready_q   <= '0;
      res_valid_q   <= '0;
      m_req_valid_q <= 1'b0;
      m_res_ready_q <= 1'b0;
      req_busy_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      g_q           <= g_d;
      m_x_q         <= m_x_d;
      m_y_q         <= m_y_d;
      z_q           <= z_d;
      req_ready_q   <= req_ready_d;
      res_valid_q   <= res_valid_d;
      m_req_valid_q <= m_req_valid_d;
      m_res_ready_q <= m_res_ready_d;
      req_busy_q    <= req_busy_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign res_valid   = res_valid_q;
  assign req_busy    = req_busy_q;
  assign Z           = z_q;
  assign m_X         = m_x_q;
  assign m_Y         = m_y_q;
  assign m_req_valid = m_req_valid_q;
  assign m_res_ready = m_res_ready_q;

`ifdef MULTMOD_ARB_STATS_EN
  logic [NREQ*16-1:0] grant_cnt_q;

  // One wrapping 16-bit counter per requester, bumped on each accept pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready_q[i]) begin
          grant_cnt_q[i*16 +: 16] <= grant_cnt_q[i*16 +: 16] + 16'd1;
        end else begin
          grant_cnt_q[i*16 +: 16] <= grant_cnt_q[i*16 +: 16];
        end
      end
    end
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule
